outlier_stream_reader: RTL and testbench
========================================

// Module: outlier_stream_reader
// PURPOSE
//  Consumer end of the outlier-position FIFO filled by the point-validation controller.
//  Pops N-bit outlier indices with the FIFO's 1-cycle read latency and packs two per beat
//  onto an AXI-Stream master. Counts outliers and marks end-of-cloud with m_tlast once the
//  controller reports done and the FIFO is drained. Sits between the controller and the DMA/host path.
// PARAMETERS
//  N      16          position width; must match FIFO dout width
//  PAD    {N{1'b1}}   filler lane value for odd tail / terminator beat
// PORTS
//  clock          in   1     system clock
//  reset          in   1     synchronous, active-high
//  start          in   1     1-cycle pulse: arm reader (IDLE/DONE -> RUN)
//  fifo_dout      in   N     FIFO read data, valid 1 cycle after fifo_rd_en
//  fifo_empty     in   1     FIFO empty flag
//  fifo_rd_en     out  1     FIFO pop request
//  ctrl_done      in   1     controller finished validating the cloud (level)
//  m_tdata        out  2N    {lane1, lane0}; lane0 = earlier position
//  m_tvalid       out  1     AXI-S valid
//  m_tready       in   1     AXI-S ready
//  m_tlast        out  1     last beat of the cloud
//  outlier_count  out  2N    positions popped since start (saturating)
//  busy           out  1     state != IDLE && state != DONE
//  finished       out  1     state == DONE
// BEHAVIOUR
//  Reset: fifo_rd_en=0, m_tvalid=0, m_tlast=0, m_tdata=0, outlier_count=0, busy=0,
//   finished=0, state=IDLE, skid empty, in-flight read flag cleared. Reset mid-operation aborts
//   the stream with no tlast; the FIFO shares this reset, so in-flight data is discarded.
//  States: IDLE -start-> RUN; RUN -(ctrl_done & fifo_empty & !inflight)-> DRAIN;
//   DRAIN: fifo_empty & ctrl_done for 2 consecutive cycles -> LAST, else !fifo_empty -> RUN;
//   LAST: after the tlast beat handshakes -> DONE; DONE -start-> RUN (count cleared, lane cleared).
//  start outside IDLE/DONE is ignored.
//  Read side: 2-entry position skid buffer. fifo_rd_en=1 only in RUN/DRAIN when !fifo_empty
//   and (skid_occupancy + inflight) < 2. Never asserted when fifo_empty=1.
//   Each fifo_dout captured the cycle after rd_en goes into skid; outlier_count += 1, saturating at all-ones.
//  Packing: positions leave the skid in order into lane0, then lane1. When both lanes are
//   full, load the output register if it is free (m_tvalid=0 or m_tready=1 this cycle).
//  Throughput: 1 position/cycle sustained while m_tready=1.
//  AXI-S: m_tdata/m_tlast stable while m_tvalid & !m_tready; m_tvalid never drops without handshake.
//  End: entering LAST with lane0 pending -> beat {PAD, lane0}, tlast=1. With no lane pending
//   -> terminator beat {PAD, PAD}, tlast=1. Exactly one tlast per start.
//  DRAIN 2-cycle window covers the controller's final write reaching FIFO empty flag.
//  outlier_count holds its value in DONE until the next start or reset.
// TESTING
//  1 start; FIFO holds 0x0003,0x0007,0x0010,0x0021; ctrl_done=1; tready=1 -> beats
//    0x00070003, 0x00210010, 0xFFFFFFFF(tlast); outlier_count=4; finished=1.
//  2 Three positions 0x0003,0x0007,0x0010 -> 0x00070003, 0xFFFF0010(tlast); count=3.
//  3 Zero outliers, ctrl_done=1 at start -> single 0xFFFFFFFF tlast beat; count=0.
//  4 Eight positions, tready=0 for 10 cycles mid-stream -> tdata stable while stalled;
//    rd_en stops when skid+inflight=2; all 4 beats in order, no loss or duplication.
//  5 Late write: ctrl_done rises 1 cycle before final FIFO write lands -> position included;
//    tlast only on the final beat.
//  6 Assert reset with 3 beats pending -> next cycle all outputs 0, IDLE. Then start after DONE
//    -> count restarts from 0.
//  Bench checks throughout: fifo_rd_en & fifo_empty never both 1.

Source files
------------

// File: rtl/outlier_stream_reader.sv
// outlier_stream_reader
// Drains the outlier-position FIFO (1-cycle read latency) through a 2-entry
// skid buffer, packs two positions per AXI-Stream beat, counts positions and
// closes each cloud with exactly one tlast beat once the controller is done
// and the FIFO has stayed empty for two DRAIN cycles.
//
// Handshakes: a beat transfers on a clock edge where m_tvalid & m_tready are
// both high; once m_tvalid is raised, m_tdata/m_tlast/m_tvalid hold until that
// transfer. fifo_rd_en is a pop request honoured at the next edge, with data
// on fifo_dout during the following cycle; it is never raised while fifo_empty.
module outlier_stream_reader #(
  parameter int N = 16,
  parameter logic [N-1:0] PAD = {N{1'b1}}
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   fifo_dout,
  input  logic           fifo_empty,
  output logic           fifo_rd_en,
  input  logic           ctrl_done,
  output logic [2*N-1:0] m_tdata,
  output logic           m_tvalid,
  input  logic           m_tready,
  output logic           m_tlast,
  output logic [2*N-1:0] outlier_count,
  output logic           busy,
  output logic           finished,
  output logic [2:0]     debug_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_LAST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t       state;
  logic         inflight;
  logic [N-1:0] skid_mem [2];
  logic         skid_wr_ptr;
  logic         skid_rd_ptr;
  logic [1:0]   skid_cnt;
  logic [N-1:0] lane0;
  logic [N-1:0] lane1;
  logic [1:0]   lane_cnt;
  logic         drain_seen;

  logic         active;
  logic         out_free;
  logic         load_pair;
  logic         lane_accept;
  logic         pop;
  logic [1:0]   occ_after;
  logic [N-1:0] skid_head;

  // Datapath steering: when the lane pair moves out, when the skid pops, and
  // whether another FIFO read fits (occupancy counted after this cycle's pop so
  // a steady stream sustains one position per cycle).
  always_comb begin
    active      = (state == S_RUN) || (state == S_DRAIN);
    out_free    = !m_tvalid || m_tready;
    load_pair   = (lane_cnt == 2'd2) && out_free;
    lane_accept = (lane_cnt != 2'd2) || load_pair;
    pop         = active && (skid_cnt != 2'd0) && lane_accept;
    skid_head   = skid_mem[skid_rd_ptr];
    occ_after   = skid_cnt - {1'b0, pop} + {1'b0, inflight};
    fifo_rd_en  = active && !fifo_empty && (occ_after < 2'd2);
  end

  assign busy        = (state == S_RUN) || (state == S_DRAIN) || (state == S_LAST);
  assign finished    = (state == S_DONE);
  assign debug_state = state;

  // Control FSM, skid buffer, lane packing, output register and counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      inflight      <= 1'b0;
      skid_wr_ptr   <= 1'b0;
      skid_rd_ptr   <= 1'b0;
      skid_cnt      <= 2'd0;
      lane0         <= '0;
      lane1         <= '0;
      lane_cnt      <= 2'd0;
      drain_seen    <= 1'b0;
      m_tdata       <= '0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
      outlier_count <= '0;
    end else begin
      // Read return lands in the skid the cycle after the pop request.
      inflight <= fifo_rd_en;
      if (inflight) begin
        skid_mem[skid_wr_ptr] <= fifo_dout;
        skid_wr_ptr           <= !skid_wr_ptr;
        if (outlier_count != '1)
          outlier_count <= outlier_count + 1'b1;
      end
      if (pop)
        skid_rd_ptr <= !skid_rd_ptr;
      skid_cnt <= skid_cnt + {1'b0, inflight} - {1'b0, pop};

      // Lane packing and output register.
      if (load_pair) begin
        m_tdata  <= {lane1, lane0};
        m_tvalid <= 1'b1;
        m_tlast  <= 1'b0;
        if (pop) begin
          lane0    <= skid_head;
          lane_cnt <= 2'd1;
        end else begin
          lane_cnt <= 2'd0;
        end
      end else begin
        if (m_tvalid && m_tready) begin
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
        end
        if (pop) begin
          if (lane_cnt == 2'd0)
            lane0 <= skid_head;
          else
            lane1 <= skid_head;
          lane_cnt <= lane_cnt + 2'd1;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_RUN;
            outlier_count <= '0;
            lane_cnt      <= 2'd0;
            drain_seen    <= 1'b0;
          end
        end
        S_RUN: begin
          if (ctrl_done && fifo_empty && !inflight) begin
            state      <= S_DRAIN;
            drain_seen <= 1'b0;
          end
        end
        S_DRAIN: begin
          // A late controller write shows up as a non-empty FIFO here.
          if (!fifo_empty) begin
            state <= S_RUN;
          end else if (ctrl_done) begin
            if (drain_seen && (skid_cnt == 2'd0) && (lane_cnt != 2'd2))
              state <= S_LAST;
            drain_seen <= 1'b1;
          end else begin
            drain_seen <= 1'b0;
          end
        end
        S_LAST: begin
          if (!m_tlast && out_free) begin
            m_tdata  <= {PAD, (lane_cnt == 2'd1) ? lane0 : PAD};
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b1;
            lane_cnt <= 2'd0;
          end else if (m_tvalid && m_tready && m_tlast) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outlier_stream_reader.sv
// Bench for outlier_stream_reader: behavioural FIFO with 1-cycle read latency,
// AXI-S sink with selectable ready pattern, and an end-of-cloud scoreboard that
// derives the expected beat list from the positions written.
module tb_outlier_stream_reader;
  localparam int N = 16;
  localparam int W = 2 * N;
  localparam logic [N-1:0] PAD = {N{1'b1}};

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   fifo_dout = '0;
  logic           fifo_empty = 1'b1;
  logic           fifo_rd_en;
  logic           ctrl_done = 1'b0;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tready = 1'b0;
  logic           m_tlast;
  logic [W-1:0]   outlier_count;
  logic           busy;
  logic           finished;
  logic [2:0]     debug_state;

  int             n_checks = 0;
  int             n_fail = 0;
  logic [W:0]     exp_q[$];
  logic [W:0]     obs_q[$];
  logic [N-1:0]   ref_pos[$];
  logic [N-1:0]   fifo_q[$];
  logic [N-1:0]   wr_q[$];
  int             ready_mode = 0;
  logic           rd_s = 1'b0;
  logic           prev_stall = 1'b0;
  logic [W+1:0]   prev_out = '0;

  outlier_stream_reader #(.N(N), .PAD(PAD)) dut (
    .clock(clock), .reset(reset), .start(start),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .ctrl_done(ctrl_done),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .outlier_count(outlier_count), .busy(busy), .finished(finished),
    .debug_state(debug_state)
  );

  // Clock and reset block
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural FIFO: pops requested during the previous cycle, one write per cycle.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      fifo_q.delete();
      wr_q.delete();
      fifo_dout = '0;
    end else begin
      if (rd_s && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      if (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // Sink ready pattern: 0 always ready, 1 random, 2 stalled.
  always @(posedge clock) begin
    #3;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  // Monitor: mid-cycle sampling of pop requests, beats and stall stability.
  always @(negedge clock) begin
    rd_s = fifo_rd_en;
    if (!reset) begin
      check("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
      if (prev_stall) check("stall_hold", {m_tvalid, m_tlast, m_tdata}, prev_out);
      if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tvalid, m_tlast, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic write_pos(input logic [N-1:0] v);
    wr_q.push_back(v);
    ref_pos.push_back(v);
  endtask

  // Scoreboard: waits for the cloud to finish, then compares every beat with
  // the list derived from the written positions (pairs, then the tlast beat).
  task automatic finish_cloud(input string tag);
    int guard;
    logic [W:0] e;
    logic [W:0] o;
    guard = 0;
    while (!finished && guard < 3000) begin
      tick();
      guard++;
    end
    check({tag, "_finished"}, finished, 1);
    exp_q.delete();
    for (int i = 0; i + 1 < ref_pos.size(); i += 2)
      exp_q.push_back({1'b0, ref_pos[i+1], ref_pos[i]});
    if (ref_pos.size() % 2 == 1)
      exp_q.push_back({1'b1, PAD, ref_pos[ref_pos.size()-1]});
    else
      exp_q.push_back({1'b1, PAD, PAD});
    check({tag, "_beat_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_beat"}, o, e);
    end
    check({tag, "_outlier_count"}, outlier_count, ref_pos.size());
    check({tag, "_busy"}, busy, 0);
    ctrl_done = 1'b0;
    obs_q.delete();
    ref_pos.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) tick();
    check("reset_tvalid", m_tvalid, 0);
    check("reset_tlast", m_tlast, 0);
    check("reset_tdata", m_tdata, 0);
    check("reset_count", outlier_count, 0);
    check("reset_busy", busy, 0);
    check("reset_finished", finished, 0);
    check("reset_rd_en", fifo_rd_en, 0);
    reset = 1'b0;
    tick();

    // Four positions preloaded, controller already done.
    write_pos(16'h0003); write_pos(16'h0007); write_pos(16'h0010); write_pos(16'h0021);
    repeat (6) tick();
    ctrl_done = 1'b1;
    pulse_start();
    finish_cloud("t1_four");

    // Odd count: lane0 tail padded with lane1 filler.
    write_pos(16'h0003); write_pos(16'h0007); write_pos(16'h0010);
    repeat (5) tick();
    ctrl_done = 1'b1;
    pulse_start();
    finish_cloud("t2_three");

    // Empty cloud: terminator beat only.
    ctrl_done = 1'b1;
    pulse_start();
    finish_cloud("t3_empty");

    // Eight positions with a 10-cycle sink stall early in the stream.
    for (int i = 0; i < 8; i++) write_pos(16'(16'h0100 + i * 3));
    repeat (10) tick();
    pulse_start();
    tick();
    ready_mode = 2;
    repeat (10) tick();
    check("t4_stall_fifo_nonempty", fifo_empty, 0);
    check("t4_stall_rd_en", fifo_rd_en, 0);
    ready_mode = 0;
    ctrl_done = 1'b1;
    finish_cloud("t4_stall");

    // Late write: done rises one cycle before the last write reaches the FIFO.
    pulse_start();
    write_pos(16'h0011); write_pos(16'h0022);
    repeat (10) tick();
    ctrl_done = 1'b1;
    write_pos(16'h0033);
    finish_cloud("t5_late");

    // Reset mid-stream with beats pending, then restart twice.
    for (int i = 0; i < 8; i++) write_pos(16'(16'h0200 + i));
    repeat (10) tick();
    pulse_start();
    ready_mode = 2;
    repeat (12) tick();
    reset = 1'b1;
    tick();
    check("t6_tvalid", m_tvalid, 0);
    check("t6_tlast", m_tlast, 0);
    check("t6_tdata", m_tdata, 0);
    check("t6_count", outlier_count, 0);
    check("t6_busy", busy, 0);
    check("t6_finished", finished, 0);
    check("t6_rd_en", fifo_rd_en, 0);
    reset = 1'b0;
    ready_mode = 0;
    ref_pos.delete();
    obs_q.delete();
    tick();
    pulse_start();
    write_pos(16'h0A0A); write_pos(16'h0B0B);
    ctrl_done = 1'b1;
    finish_cloud("t6_after_reset");
    pulse_start();
    check("t6_count_restart", outlier_count, 0);
    write_pos(16'h0C0C);
    ctrl_done = 1'b1;
    finish_cloud("t6_restart");

    // Randomized clouds with random sink backpressure and write gaps.
    ready_mode = 1;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(0, 11);
      pulse_start();
      for (int i = 0; i < n; i++) begin
        write_pos(16'($urandom_range(0, 16'hFFFF)));
        repeat ($urandom_range(0, 3)) tick();
      end
      ctrl_done = 1'b1;
      finish_cloud("rand");
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
